ppm16_byte_fifo: RTL and testbench

Downstream consumer of the 16-PPM demodulator. Packs consecutive 4-bit demodulated symbols into bytes and tags the first byte of each packet. Buffers the bytes in a first-word-fall-through FIFO that the readout/scan logic drains with a valid/read-enable handshake. Sticky flags record overflow and packet-boundary nibble misalignment.

---
 rtl/ppm16_byte_fifo_if.sv | 27 ++
 rtl/ppm16_byte_fifo.sv | 108 ++++++++++
 tb/tb_ppm16_byte_fifo.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/ppm16_byte_fifo_if.sv
// Symbol-in / byte-out handshake bundle between the 16-PPM demodulator,
// the byte FIFO and its reader.
interface ppm16_byte_fifo_if #(
    parameter int DEPTH = 16
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic [3:0]      sym_in;
    logic            sym_valid;
    logic            packet_start;
    logic            rd_en;
    logic [7:0]      dout;
    logic            dout_sop;
    logic            dout_valid;
    logic            full;
    logic [ADDR_W:0] count;

    modport master (
        output sym_in, sym_valid, packet_start, rd_en,
        input  dout, dout_sop, dout_valid, full, count
    );

    modport slave (
        input  sym_in, sym_valid, packet_start, rd_en,
        output dout, dout_sop, dout_valid, full, count
    );
endinterface

// File: rtl/ppm16_byte_fifo.sv
// Packs demodulated 4-bit PPM symbols into bytes, tags packet starts and
// buffers them in a first-word-fall-through FIFO with sticky error flags.
module ppm16_byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic              clk,
    input  logic              reset,
    ppm16_byte_fifo_if.slave  bus,
    input  logic              clear_flags,
    output logic              overflow,
    output logic              misalign
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

    typedef enum logic {S_HI, S_LO} state_t;

    typedef struct packed {
        logic       sop;
        logic [7:0] data;
    } entry_t;

    entry_t            mem [DEPTH];
    entry_t            head;
    state_t            state;
    logic [3:0]        hi;
    logic              sop_pending;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   cnt;

    logic wr_req;
    logic pop;
    logic push;
    logic full_q;
    logic ovf_ev;
    logic mis_ev;

    // A packet_start in S_LO wins over a completing symbol: the held nibble is dropped.
    assign wr_req = (state == S_LO) && bus.sym_valid && !bus.packet_start;
    assign full_q = (cnt == FULL_CNT);
    assign pop    = bus.rd_en && (cnt != '0);
    assign push   = wr_req && (!full_q || pop);
    assign ovf_ev = wr_req && full_q && !pop;
    assign mis_ev = bus.packet_start && (state == S_LO);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_HI;
            hi          <= '0;
            sop_pending <= 1'b0;
        end else if (bus.packet_start) begin
            sop_pending <= 1'b1;
            if (bus.sym_valid) begin
                hi    <= bus.sym_in;
                state <= S_LO;
            end else begin
                state <= S_HI;
            end
        end else if (bus.sym_valid) begin
            if (state == S_HI) begin
                hi    <= bus.sym_in;
                state <= S_LO;
            end else begin
                sop_pending <= 1'b0;
                state       <= S_HI;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{sop: sop_pending, data: {hi, bus.sym_in}};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Set wins over clear when both land in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
            misalign <= 1'b0;
        end else begin
            overflow <= (overflow && !clear_flags) || ovf_ev;
            misalign <= (misalign && !clear_flags) || mis_ev;
        end
    end

    assign head           = mem[rd_ptr];
    assign bus.count      = cnt;
    assign bus.full       = full_q;
    assign bus.dout_valid = (cnt != '0);
    assign bus.dout       = bus.dout_valid ? head.data : 8'h00;
    assign bus.dout_sop   = bus.dout_valid ? head.sop  : 1'b0;
endmodule

// File: tb/tb_ppm16_byte_fifo.sv
// Directed bench for ppm16_byte_fifo: packing, tagging, flags, full/overflow and wrap.
module tb_ppm16_byte_fifo;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic clear_flags = 1'b0;
    logic overflow;
    logic misalign;
    int   checks = 0;
    int   failures = 0;

    ppm16_byte_fifo_if #(.DEPTH(16)) bus ();

    ppm16_byte_fifo #(.DEPTH(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .clear_flags (clear_flags),
        .overflow    (overflow),
        .misalign    (misalign)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, let the edge take them, then return strobes to idle.
    task automatic step(input logic sv, input logic [3:0] s, input logic ps,
                        input logic rd, input logic cf);
        bus.sym_valid    = sv;
        bus.sym_in       = s;
        bus.packet_start = ps;
        bus.rd_en        = rd;
        clear_flags      = cf;
        @(posedge clk);
        #1;
        bus.sym_valid    = 1'b0;
        bus.sym_in       = 4'h0;
        bus.packet_start = 1'b0;
        bus.rd_en        = 1'b0;
        clear_flags      = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] b, input logic rd);
        step(1'b1, b[7:4], 1'b0, 1'b0, 1'b0);
        step(1'b1, b[3:0], 1'b0, rd, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    logic [7:0] wb [40];
    int         rd_idx;
    int         guard;

    initial begin
        bus.sym_in = 4'h0; bus.sym_valid = 1'b0; bus.packet_start = 1'b0; bus.rd_en = 1'b0;
        do_reset();
        chk("rst_count", 32'(bus.count), 0);
        chk("rst_valid", 32'(bus.dout_valid), 0);
        chk("rst_dout", 32'(bus.dout), 0);
        chk("rst_sop", 32'(bus.dout_sop), 0);
        chk("rst_full", 32'(bus.full), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_mis", 32'(misalign), 0);

        // Basic pack
        step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 4'hA, 1'b0, 1'b0, 1'b0);
        chk("bp_empty_mid", 32'(bus.dout_valid), 0);
        step(1'b1, 4'h5, 1'b0, 1'b0, 1'b0);
        chk("bp_cnt1", 32'(bus.count), 1);
        chk("bp_dout1", 32'(bus.dout), 32'hA5);
        chk("bp_sop1", 32'(bus.dout_sop), 1);
        push_byte(8'h3C, 1'b0);
        chk("bp_cnt2", 32'(bus.count), 2);
        step(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
        chk("bp_dout2", 32'(bus.dout), 32'h3C);
        chk("bp_sop2", 32'(bus.dout_sop), 0);
        chk("bp_cnt1b", 32'(bus.count), 1);
        step(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
        chk("bp_cnt0", 32'(bus.count), 0);
        chk("bp_valid0", 32'(bus.dout_valid), 0);
        step(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
        chk("bp_underflow_cnt", 32'(bus.count), 0);

        // Misalign, then set-wins and packet_start with coincident symbol
        step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 4'h7, 1'b0, 1'b0, 1'b0);
        step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
        push_byte(8'h12, 1'b0);
        chk("ma_cnt", 32'(bus.count), 1);
        chk("ma_dout", 32'(bus.dout), 32'h12);
        chk("ma_sop", 32'(bus.dout_sop), 1);
        chk("ma_flag", 32'(misalign), 1);
        step(1'b0, 4'h0, 1'b0, 1'b1, 1'b1);
        chk("ma_clear", 32'(misalign), 0);
        step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 4'h9, 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'h4, 1'b1, 1'b0, 1'b1);
        chk("ma_setwins", 32'(misalign), 1);
        chk("ma_nowrite", 32'(bus.count), 0);
        step(1'b1, 4'h8, 1'b0, 1'b0, 1'b0);
        chk("ma_ps_sym_dout", 32'(bus.dout), 32'h48);
        chk("ma_ps_sym_sop", 32'(bus.dout_sop), 1);

        // Fill / overflow / full with concurrent pop
        do_reset();
        step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) push_byte(8'h10 + 8'(i), 1'b0);
        chk("fl_full", 32'(bus.full), 1);
        chk("fl_cnt", 32'(bus.count), 16);
        chk("fl_ovf0", 32'(overflow), 0);
        push_byte(8'h20, 1'b0);
        chk("fl_ovf1", 32'(overflow), 1);
        chk("fl_cnt17", 32'(bus.count), 16);
        chk("fl_head", 32'(bus.dout), 32'h10);
        chk("fl_head_sop", 32'(bus.dout_sop), 1);
        step(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
        chk("fl_ovf_clr", 32'(overflow), 0);
        push_byte(8'hEE, 1'b1);
        chk("fp_cnt", 32'(bus.count), 16);
        chk("fp_ovf", 32'(overflow), 0);
        chk("fp_head", 32'(bus.dout), 32'h11);
        chk("fp_sop", 32'(bus.dout_sop), 0);
        for (int i = 0; i < 16; i++) begin
            chk("fp_drain", 32'(bus.dout), (i < 15) ? 32'(8'h11 + 8'(i)) : 32'hEE);
            step(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
        end
        chk("fp_empty", 32'(bus.count), 0);
        chk("fp_notfull", 32'(bus.full), 0);

        // Wrap-around stream
        do_reset();
        for (int i = 0; i < 40; i++) wb[i] = 8'(i * 37 + 5);
        rd_idx = 0;
        step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
        for (int c = 0; c < 80; c++) begin
            if ((c % 2) == 1 && bus.dout_valid) begin
                chk("wr_data", 32'(bus.dout), 32'(wb[rd_idx]));
                chk("wr_sop", 32'(bus.dout_sop), (rd_idx == 0) ? 1 : 0);
                rd_idx++;
            end
            if ((c % 2) == 0) step(1'b1, wb[c/2][7:4], 1'b0, 1'b0, 1'b0);
            else              step(1'b1, wb[c/2][3:0], 1'b0, 1'b1, 1'b0);
        end
        guard = 0;
        while (bus.dout_valid && guard < 100) begin
            chk("wr_data", 32'(bus.dout), 32'(wb[rd_idx]));
            chk("wr_sop", 32'(bus.dout_sop), (rd_idx == 0) ? 1 : 0);
            rd_idx++;
            guard++;
            step(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
        end
        chk("wr_total", 32'(rd_idx), 40);
        chk("wr_ovf", 32'(overflow), 0);

        // Reset mid-operation
        do_reset();
        step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) push_byte(8'h31 + 8'(i), 1'b0);
        step(1'b1, 4'h6, 1'b0, 1'b0, 1'b0);
        step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 4'h9, 1'b0, 1'b0, 1'b0);
        chk("rm_cnt5", 32'(bus.count), 5);
        chk("rm_mis_pre", 32'(misalign), 1);
        do_reset();
        chk("rm_cnt0", 32'(bus.count), 0);
        chk("rm_valid0", 32'(bus.dout_valid), 0);
        chk("rm_mis0", 32'(misalign), 0);
        chk("rm_ovf0", 32'(overflow), 0);
        push_byte(8'hBD, 1'b0);
        chk("rm_dout", 32'(bus.dout), 32'hBD);
        chk("rm_sop", 32'(bus.dout_sop), 0);
        chk("rm_cnt1", 32'(bus.count), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
